snake_step_ctrl: RTL and testbench

- Frame-synchronous game controller that sequences writes into the framebuffer (pdmem write port) to animate the snake drawn by the VGA path.
- Once per N frames it:
  - advances the head one grid cell;
  - checks wall and self collision;
  - erases the tail cell, unless the snake is growing;
  - paints the new head cell.
- The snake body is stored as a circular buffer of cell coordinates.
- Sits between the PS/2 key decoder and the pdmem write port, clocked by the VGA clock.

---
 rtl/snake_pkg.sv | 29 ++
 rtl/cell_painter.sv | 75 +++++++
 rtl/snake_step_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_snake_step_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared encodings and geometry defaults for the snake step controller.
package snake_pkg;

  localparam logic [3:0] DIR_UP    = 4'b1000;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b0010;
  localparam logic [3:0] DIR_RIGHT = 4'b0001;

  localparam int H_RES_DEF  = 640;
  localparam int CELL_DEF   = 8;
  localparam int GRID_W_DEF = 80;
  localparam int GRID_H_DEF = 60;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_CHECK,
    S_ERASE,
    S_DRAW,
    S_DEAD
  } state_t;

  // Swaps up<->down and left<->right within the one-hot encoding.
  function automatic logic [3:0] opposite(input logic [3:0] d);
    return {d[2], d[3], d[0], d[1]};
  endfunction

endpackage

// File: rtl/cell_painter.sv
// Fills one CELL x CELL square of the framebuffer with a single colour,
// one pixel per cycle in raster order (x fastest).
module cell_painter
  import snake_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int CELL  = CELL_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic [6:0]  cx,
  input  logic [5:0]  cy,
  input  logic [7:0]  colour,
  output logic [18:0] fb_addr,
  output logic [7:0]  fb_data,
  output logic        fb_wren,
  output logic        done
);

  localparam int PW = (CELL > 1) ? $clog2(CELL) : 1;

  logic [PW-1:0] px;
  logic [PW-1:0] py;
  logic [6:0]    cx_r;
  logic [5:0]    cy_r;
  logic [7:0]    col_r;
  logic          active;
  logic          last;

  assign last = (px == PW'(CELL - 1)) && (py == PW'(CELL - 1));

  // Handshake: go is a one-cycle request sampled only while idle; coordinates
  // and colour are captured with it. done pulses for one cycle after the last pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      active <= 1'b0;
      done   <= 1'b0;
      px     <= '0;
      py     <= '0;
      cx_r   <= '0;
      cy_r   <= '0;
      col_r  <= '0;
    end else begin
      done <= 1'b0;
      if (go && !active) begin
        active <= 1'b1;
        px     <= '0;
        py     <= '0;
        cx_r   <= cx;
        cy_r   <= cy;
        col_r  <= colour;
      end else if (active) begin
        if (last) begin
          active <= 1'b0;
          done   <= 1'b1;
        end else if (px == PW'(CELL - 1)) begin
          px <= '0;
          py <= py + PW'(1);
        end else begin
          px <= px + PW'(1);
        end
      end
    end
  end

  always_comb begin
    fb_addr = (19'(cy_r) * 19'(CELL) + 19'(py)) * 19'(H_RES)
            + 19'(cx_r) * 19'(CELL) + 19'(px);
  end

  assign fb_data = col_r;
  assign fb_wren = active;

endmodule

// File: rtl/snake_step_ctrl.sv
// Frame-synchronous snake controller: steps the head every N frames, checks
// collisions against a circular body buffer and repaints tail/head cells.
module snake_step_ctrl
  import snake_pkg::*;
#(
  parameter int         H_RES           = H_RES_DEF,
  parameter int         CELL            = CELL_DEF,
  parameter int         GRID_W          = GRID_W_DEF,
  parameter int         GRID_H          = GRID_H_DEF,
  parameter int         MAX_LEN         = 64,
  parameter int         FRAMES_PER_STEP = 6,
  parameter logic [7:0] SNAKE_IDX       = 8'd5,
  parameter logic [7:0] BG_IDX          = 8'd0,
  parameter int         START_X         = 40,
  parameter int         START_Y         = 30
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic        vsync_n,
  input  logic        start,
  input  logic        key_valid,
  input  logic [3:0]  key_dir,
  input  logic        grow,
  output logic [18:0] fb_addr,
  output logic [7:0]  fb_data,
  output logic        fb_wren,
  output logic [6:0]  head_x,
  output logic [5:0]  head_y,
  output logic [6:0]  length,
  output logic        game_over,
  output logic        busy,
  output state_t      dbg_state
);

  localparam int PW = $clog2(MAX_LEN);
  localparam int CW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  state_t        state;
  logic          prev_vs;
  logic          tick;
  logic [CW-1:0] frame_cnt;
  logic          last_frame;
  logic [3:0]    dir;
  logic [3:0]    pend_dir;
  logic          key_ok;
  logic          grow_pend;
  logic          grow_now;
  logic [6:0]    body_x [MAX_LEN];
  logic [5:0]    body_y [MAX_LEN];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] scan_ptr;
  logic [6:0]    scan_left;
  logic          hit;
  logic [6:0]    nxt_x;
  logic [5:0]    nxt_y;
  logic [7:0]    cand_x;
  logic [6:0]    cand_y;
  logic          cand_out;
  logic          paint_go;
  logic [6:0]    paint_x;
  logic [5:0]    paint_y;
  logic [7:0]    paint_col;
  logic          paint_done;

  assign tick       = prev_vs & ~vsync_n;
  assign last_frame = (frame_cnt == CW'(FRAMES_PER_STEP - 1));

  // Rejecting reversal against both the applied and the pending direction
  // keeps a quick UP-then-DOWN from folding the head back onto the neck.
  assign key_ok = key_valid && $onehot(key_dir)
               && (key_dir != opposite(dir))
               && (key_dir != opposite(pend_dir));

  assign hit = (scan_left != 7'd0)
            && (body_x[scan_ptr] == nxt_x) && (body_y[scan_ptr] == nxt_y);

  // One extra bit on each axis so that stepping below 0 wraps to a large,
  // out-of-range value and is caught by the same bound check.
  always_comb begin
    cand_x = {1'b0, head_x};
    cand_y = {1'b0, head_y};
    case (pend_dir)
      DIR_UP:    cand_y = cand_y - 7'd1;
      DIR_DOWN:  cand_y = cand_y + 7'd1;
      DIR_LEFT:  cand_x = cand_x - 8'd1;
      default:   cand_x = cand_x + 8'd1;
    endcase
    cand_out = (cand_x >= 8'(GRID_W)) || (cand_y >= 7'(GRID_H));
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state     <= S_IDLE;
      prev_vs   <= 1'b1;
      frame_cnt <= '0;
      dir       <= DIR_RIGHT;
      pend_dir  <= DIR_RIGHT;
      grow_pend <= 1'b0;
      grow_now  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      scan_ptr  <= '0;
      scan_left <= '0;
      nxt_x     <= 7'(START_X);
      nxt_y     <= 6'(START_Y);
      head_x    <= 7'(START_X);
      head_y    <= 6'(START_Y);
      length    <= 7'd1;
      game_over <= 1'b0;
      paint_go  <= 1'b0;
      paint_x   <= '0;
      paint_y   <= '0;
      paint_col <= '0;
    end else begin
      prev_vs  <= vsync_n;
      paint_go <= 1'b0;
      if (key_ok)
        pend_dir <= key_dir;
      if (grow && state != S_IDLE && state != S_DEAD && length != 7'(MAX_LEN))
        grow_pend <= 1'b1;
      // Saturate while busy so a missed step fires on the first tick back in RUN.
      if (tick && busy && !last_frame)
        frame_cnt <= frame_cnt + CW'(1);

      case (state)
        S_IDLE: begin
          if (start) state <= S_INIT;
        end
        S_INIT: begin
          body_x[0] <= 7'(START_X);
          body_y[0] <= 6'(START_Y);
          wr_ptr    <= PW'(1);
          rd_ptr    <= '0;
          length    <= 7'd1;
          dir       <= DIR_RIGHT;
          pend_dir  <= DIR_RIGHT;
          game_over <= 1'b0;
          grow_pend <= 1'b0;
          frame_cnt <= '0;
          head_x    <= 7'(START_X);
          head_y    <= 6'(START_Y);
          paint_go  <= 1'b1;
          paint_x   <= 7'(START_X);
          paint_y   <= 6'(START_Y);
          paint_col <= SNAKE_IDX;
          state     <= S_DRAW;
        end
        S_RUN: begin
          if (tick) begin
            if (last_frame) begin
              frame_cnt <= '0;
              dir       <= pend_dir;
              if (cand_out) begin
                game_over <= 1'b1;
                state     <= S_DEAD;
              end else begin
                nxt_x     <= cand_x[6:0];
                nxt_y     <= cand_y[5:0];
                grow_now  <= grow_pend;
                scan_ptr  <= grow_pend ? rd_ptr : rd_ptr + PW'(1);
                scan_left <= grow_pend ? length : length - 7'd1;
                state     <= S_CHECK;
              end
            end else begin
              frame_cnt <= frame_cnt + CW'(1);
            end
          end
        end
        S_CHECK: begin
          if (hit) begin
            game_over <= 1'b1;
            state     <= S_DEAD;
          end else if (scan_left <= 7'd1) begin
            body_x[wr_ptr] <= nxt_x;
            body_y[wr_ptr] <= nxt_y;
            wr_ptr         <= wr_ptr + PW'(1);
            head_x         <= nxt_x;
            head_y         <= nxt_y;
            paint_go       <= 1'b1;
            if (grow_now) begin
              length    <= length + 7'd1;
              grow_pend <= 1'b0;
              paint_x   <= nxt_x;
              paint_y   <= nxt_y;
              paint_col <= SNAKE_IDX;
              state     <= S_DRAW;
            end else begin
              // Tail read here sees the pre-push value even when a full buffer wraps onto it.
              paint_x   <= body_x[rd_ptr];
              paint_y   <= body_y[rd_ptr];
              paint_col <= BG_IDX;
              state     <= S_ERASE;
            end
          end else begin
            scan_ptr  <= scan_ptr + PW'(1);
            scan_left <= scan_left - 7'd1;
          end
        end
        S_ERASE: begin
          if (paint_done) begin
            rd_ptr    <= rd_ptr + PW'(1);
            paint_go  <= 1'b1;
            paint_x   <= head_x;
            paint_y   <= head_y;
            paint_col <= SNAKE_IDX;
            state     <= S_DRAW;
          end
        end
        S_DRAW: begin
          if (paint_done) state <= S_RUN;
        end
        S_DEAD: begin
          if (start) state <= S_INIT;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state == S_CHECK) || (state == S_ERASE) || (state == S_DRAW);
  assign dbg_state = state;

  cell_painter #(
    .H_RES (H_RES),
    .CELL  (CELL)
  ) u_painter (
    .clk     (vga_clk),
    .reset   (reset),
    .go      (paint_go),
    .cx      (paint_x),
    .cy      (paint_y),
    .colour  (paint_col),
    .fb_addr (fb_addr),
    .fb_data (fb_data),
    .fb_wren (fb_wren),
    .done    (paint_done)
  );

endmodule

// File: tb/tb_snake_step_ctrl.sv
// Bench for snake_step_ctrl: framebuffer writes go through an expected-write
// scoreboard; head/length/flags are checked against hand-computed constants.
module tb_snake_step_ctrl;
  import snake_pkg::*;

  localparam int H_RES   = 640;
  localparam int CELL    = 8;
  localparam int FPS     = 2;
  localparam int MAX_LEN = 8;
  localparam int SNAKE   = 5;
  localparam int BG      = 0;

  logic        clk = 1'b0;
  logic        reset;
  logic        vsync_n;
  logic        start;
  logic        key_valid;
  logic [3:0]  key_dir;
  logic        grow;
  logic [18:0] fb_addr;
  logic [7:0]  fb_data;
  logic        fb_wren;
  logic [6:0]  head_x;
  logic [5:0]  head_y;
  logic [6:0]  length;
  logic        game_over;
  logic        busy;
  state_t      dbg_state;

  int          checks = 0;
  int          errors = 0;
  logic [26:0] exp_q[$];
  bit          sb_on = 1'b1;
  int          body_x[$];
  int          body_y[$];
  int          hx;
  int          hy;

  snake_step_ctrl #(
    .FRAMES_PER_STEP (FPS),
    .MAX_LEN         (MAX_LEN)
  ) dut (
    .vga_clk   (clk),
    .reset     (reset),
    .vsync_n   (vsync_n),
    .start     (start),
    .key_valid (key_valid),
    .key_dir   (key_dir),
    .grow      (grow),
    .fb_addr   (fb_addr),
    .fb_data   (fb_data),
    .fb_wren   (fb_wren),
    .head_x    (head_x),
    .head_y    (head_y),
    .length    (length),
    .game_over (game_over),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock / watchdog
  initial forever #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int cell_addr(input int x, input int y, input int px, input int py);
    return (y * CELL + py) * H_RES + x * CELL + px;
  endfunction

  task automatic expect_cell(input int x, input int y, input int col);
    for (int py = 0; py < CELL; py++)
      for (int px = 0; px < CELL; px++)
        exp_q.push_back({19'(cell_addr(x, y, px, py)), 8'(col)});
  endtask

  task automatic model_restart();
    body_x.delete();
    body_y.delete();
    hx = 40;
    hy = 30;
    body_x.push_back(hx);
    body_y.push_back(hy);
    expect_cell(hx, hy, SNAKE);
  endtask

  task automatic model_step(input logic [3:0] d, input bit g);
    case (d)
      DIR_UP:   hy = hy - 1;
      DIR_DOWN: hy = hy + 1;
      DIR_LEFT: hx = hx - 1;
      default:  hx = hx + 1;
    endcase
    if (!g) begin
      expect_cell(body_x[0], body_y[0], BG);
      void'(body_x.pop_front());
      void'(body_y.pop_front());
    end
    expect_cell(hx, hy, SNAKE);
    body_x.push_back(hx);
    body_y.push_back(hy);
  endtask

  // Driver tasks: all entered and left just after a falling edge.
  task automatic frame_tick();
    vsync_n = 1'b0;
    repeat (2) @(negedge clk);
    vsync_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_grow();
    grow = 1'b1;
    @(negedge clk);
    grow = 1'b0;
  endtask

  task automatic send_key(input logic [3:0] d);
    key_valid = 1'b1;
    key_dir   = d;
    @(negedge clk);
    key_valid = 1'b0;
    key_dir   = 4'b0000;
  endtask

  task automatic wait_settled(input string name);
    int n = 0;
    while (!(dbg_state == S_RUN || dbg_state == S_DEAD) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_settle_cycles_ok"}, int'(n < 2000), 1);
    check({name, "_pending_writes"}, exp_q.size(), 0);
  endtask

  task automatic do_step(input string name);
    repeat (FPS) frame_tick();
    wait_settled(name);
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_state"}, int'(dbg_state), int'(S_IDLE));
    check({name, "_fb_wren"}, fb_wren, 0);
    check({name, "_fb_addr"}, fb_addr, 0);
    check({name, "_fb_data"}, fb_data, 0);
    check({name, "_head_x"}, head_x, 40);
    check({name, "_head_y"}, head_y, 30);
    check({name, "_length"}, length, 1);
    check({name, "_game_over"}, game_over, 0);
    check({name, "_busy"}, busy, 0);
  endtask

  // Scoreboard monitor: every framebuffer write must match the next expected entry.
  initial begin
    logic [26:0] e;
    forever begin
      @(negedge clk);
      if (sb_on && fb_wren) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL fb_write_unexpected: addr %0d data %0d, expected no write", fb_addr, fb_data);
        end else begin
          e = exp_q.pop_front();
          if ({fb_addr, fb_data} !== e) begin
            errors++;
            $display("FAIL fb_write: addr %0d data %0d, expected addr %0d data %0d",
                     fb_addr, fb_data, e[26:8], e[7:0]);
          end
        end
      end
    end
  end

  // Directed sequence
  initial begin
    int n;
    reset     = 1'b1;
    vsync_n   = 1'b1;
    start     = 1'b0;
    key_valid = 1'b0;
    key_dir   = 4'b0000;
    grow      = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("reset");

    // Start paints the start cell; cell (40,30) begins at 240*640+320 = 153920.
    check("start_cell_base_addr", cell_addr(40, 30, 0, 0), 153920);
    model_restart();
    pulse_start();
    wait_settled("init_draw");
    check("init_state", int'(dbg_state), int'(S_RUN));

    // First step with no keys: erase (40,30), draw (41,30).
    model_step(DIR_RIGHT, 1'b0);
    do_step("step1");
    check("step1_head_x", head_x, 41);
    check("step1_head_y", head_y, 30);
    check("step1_length", length, 1);

    // LEFT is a reversal and is dropped; UP then DOWN keeps UP.
    send_key(DIR_LEFT);
    send_key(DIR_UP);
    send_key(DIR_DOWN);
    model_step(DIR_UP, 1'b0);
    do_step("step_up");
    check("step_up_head_x", head_x, 41);
    check("step_up_head_y", head_y, 29);

    // Growth: draw only, no erase.
    send_key(DIR_RIGHT);
    pulse_grow();
    model_step(DIR_RIGHT, 1'b1);
    do_step("grow1");
    check("grow1_length", length, 2);
    check("grow1_head_x", head_x, 42);

    for (int i = 0; i < 3; i++) begin
      pulse_grow();
      model_step(DIR_RIGHT, 1'b1);
      do_step("grow_more");
    end
    check("len5_length", length, 5);
    check("len5_head_x", head_x, 45);
    check("len5_head_y", head_y, 29);

    // Tight loop UP, LEFT, DOWN lands on (44,29), which is still body.
    send_key(DIR_UP);
    model_step(DIR_UP, 1'b0);
    do_step("loop_up");
    send_key(DIR_LEFT);
    model_step(DIR_LEFT, 1'b0);
    do_step("loop_left");
    send_key(DIR_DOWN);
    do_step("self_hit");
    check("self_hit_game_over", game_over, 1);
    check("self_hit_state", int'(dbg_state), int'(S_DEAD));
    check("self_hit_busy", busy, 0);
    check("self_hit_head_x", head_x, 44);
    check("self_hit_head_y", head_y, 28);
    check("self_hit_length", length, 5);

    // Restart from DEAD.
    model_restart();
    pulse_start();
    wait_settled("restart1");
    check("restart1_head_x", head_x, 40);
    check("restart1_head_y", head_y, 30);
    check("restart1_game_over", game_over, 0);
    check("restart1_length", length, 1);

    // Grow to MAX_LEN, then a further grow is ignored.
    for (int i = 0; i < MAX_LEN - 1; i++) begin
      pulse_grow();
      model_step(DIR_RIGHT, 1'b1);
      do_step("fill");
    end
    check("full_length", length, MAX_LEN);
    check("full_head_x", head_x, 47);
    pulse_grow();
    model_step(DIR_RIGHT, 1'b0);
    do_step("grow_at_max");
    check("grow_at_max_length", length, MAX_LEN);
    check("grow_at_max_head_x", head_x, 48);

    // Run to the right wall, then step off it.
    for (int i = 0; i < 31; i++) begin
      model_step(DIR_RIGHT, 1'b0);
      do_step("to_wall");
    end
    check("at_wall_head_x", head_x, 79);
    check("at_wall_state", int'(dbg_state), int'(S_RUN));
    do_step("wall");
    check("wall_game_over", game_over, 1);
    check("wall_state", int'(dbg_state), int'(S_DEAD));
    check("wall_head_x", head_x, 79);
    check("wall_length", length, MAX_LEN);

    // Reset in the middle of an erase.
    model_restart();
    pulse_start();
    wait_settled("restart2");
    check("restart2_game_over", game_over, 0);
    sb_on = 1'b0;
    repeat (FPS) frame_tick();
    n = 0;
    while (!(dbg_state == S_ERASE && fb_wren) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("erase_reached", int'(n < 500), 1);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("mid_erase_reset");
    reset = 1'b0;
    @(negedge clk);
    exp_q.delete();
    sb_on = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
